ctrl_regs_mc: RTL and testbench
===============================

# ctrl_regs_mc

Parametrised multi-channel control/status register file. It generalises the fixed three-slave control register block to `CH_NUM` slave channels and adds the following:
- per-channel availability thresholds with interrupt generation;
- a write-1-to-clear interrupt status register;
- a sticky configuration lock;
- an error flag for illegal accesses.

It sits between the command bus and the slave arbiter. It drives each slave's enable, priority and packet length, and samples each slave's FIFO availability.

## Interface
Parameters:
- `CH_NUM`, 3: number of slave channels, 1..8.
- `addr_width`, 8: command address width, ≥ 8.

Ports:
- `clk_i`  in  1  single clock; all logic is rising-edge.
- `rstn_i`  in  1  reset, asynchronous active-low.
- `cmd_i`  in  2  command: 2'b00 idle, 2'b10 write, 2'b01 read, 2'b11 treated as idle.
- `cmd_addr_i`  in  addr_width  byte address.
- `cmd_data_i`  in  32  write data.
- `cmd_data_o`  out  32  read data, registered.
- `cmd_err_o`  out  1  one-cycle error pulse.
- `slv_avail_i`  in  8*CH_NUM  channel n availability is bits [8n+7:8n].
- `slv_en_o`  out  CH_NUM  channel enables.
- `slv_prio_o`  out  2*CH_NUM  channel priorities.
- `slv_len_o`  out  3*CH_NUM  channel packet lengths.
- `irq_o`  out  1  interrupt, level, registered.

## Operation
- Register map, byte addresses, n = 0..CH_NUM-1:
  - CTRL[n] at 0x00+4n, RW. Fields: [0] en, [2:1] prio, [5:3] len. Other bits read 0, writes ignored. Reset 0.
  - STAT[n] at 0x40+4n, RO. [7:0] holds the registered copy of the channel's availability.
  - THR[n] at 0x80+4n, RW. [7:0] threshold. Reset 0; a threshold of 0 disables the channel's event.
  - IRQ_STAT at 0xF0, W1C. Bit n is channel n's sticky event.
  - IRQ_EN at 0xF4, RW. [CH_NUM-1:0]. Reset 0.
  - LOCK at 0xF8, RW. [0] lock. Writing 0x5A sets the bit; any other write leaves it unchanged. Once set it clears only on reset.
- Output fields are driven directly from CTRL[n]: `slv_en_o[n]`, `slv_prio_o[2n+1:2n]` and `slv_len_o[3n+2:3n]`.
- Availability sampling: `avail_q[n]` is a register updated with `slv_avail_i` every cycle.
- Event detection, per channel: `below[n] = (THR[n] != 0) && (avail_q[n] < THR[n])`, an unsigned 8-bit compare.
  - `below[n]` is registered each cycle.
  - An event is a rising edge of `below[n]`; it sets IRQ_STAT bit n.
- `irq_o` is registered: `|(IRQ_STAT & IRQ_EN)`.
- Writes:
  - CTRL and THR writes are ignored while LOCK=1. IRQ_EN and IRQ_STAT remain writable while locked.
  - IRQ_STAT: a 1 clears the bit. If a clear and a set of the same bit occur in the same cycle, the set wins.
- Errors: `cmd_err_o` pulses for one cycle after any of these accesses; no register changes.
  - Address with nonzero bits above [7:0].
  - Address with [1:0] != 0.
  - Unmapped offset, including channel index ≥ CH_NUM.
  - Write to STAT.
  - Write to CTRL or THR while locked.
- Reads: an erroring read returns 0.

## Timing
- Reset values: all registers 0; `cmd_data_o`=0, `cmd_err_o`=0, `irq_o`=0, all `slv_*_o`=0.
- Write: a write presented in cycle T updates the register at the edge ending T. Outputs reflect the new value in T+1.
- Read: a read presented in cycle T drives `cmd_data_o` in T+1. `cmd_data_o` holds its last value until the next read.
- Read-after-write to the same address in consecutive cycles returns the new value.
- Error: `cmd_err_o` is asserted in T+1 for an offending command in T.
- Interrupt latency: `slv_avail_i` change at edge E gives `avail_q` at E+1, `below` registered at E+2, IRQ_STAT set at E+3, `irq_o` asserted at E+4.
- A W1C clear takes effect with the same latency as any write; `irq_o` deasserts one cycle after the status bit clears.
- Asynchronous reset mid-command: every register, including LOCK and IRQ_STAT, returns to 0 immediately. No error pulse is generated for the aborted command.

## Test plan
- Reset, then read CTRL[0..CH_NUM-1], THR, IRQ_EN, LOCK → all 0, `cmd_err_o` 0, `slv_*_o` 0.
- Write CTRL[1]=0x0000_003F, then read it → `cmd_data_o`=0x3F one cycle after the read; `slv_en_o[1]`=1, prio=3, len=7. Write 0xFFFF_FFFF → read back 0x3F.
- Write LOCK=0x5A, then write CTRL[0]=0x1 → `cmd_err_o` pulses once and CTRL[0] stays 0. A subsequent write of IRQ_EN=0x1 succeeds.
- THR[2]=0x10, IRQ_EN=0x4, `slv_avail_i` ch2 goes 0x20→0x0F → IRQ_STAT=0x4 and `irq_o`=1 four cycles after the change. Write IRQ_STAT=0x4 → `irq_o`=0. Hold avail at 0x0F → no re-set.
- With CH_NUM=3: read 0x0C, read 0x41, write 0x40, and read with address bit 8 set (`addr_width`=16) → each gives one `cmd_err_o` pulse; erroring reads return 0.
- Same-cycle clear and set: issue the IRQ_STAT W1C in the cycle the ch0 event sets the bit → the bit stays 1.

Source files
------------

// File: rtl/ctrl_regs_mc.sv
// ctrl_regs_mc: multi-channel control/status register file between the
// command bus and the slave arbiter.
//   clk_i, rstn_i           : clock, asynchronous active-low reset
//   cmd_i/cmd_addr_i        : command (10 write, 01 read, else idle) and byte address
//   cmd_data_i/cmd_data_o   : write data in, registered read data out
//   cmd_err_o               : one-cycle pulse after an illegal access
//   slv_avail_i             : per-channel FIFO availability, 8 bits per channel
//   slv_en_o/prio_o/len_o   : per-channel control fields from CTRL[n]
//   irq_o                   : registered level interrupt
module ctrl_regs_mc #(
  parameter int CH_NUM     = 3,
  parameter int addr_width = 8
) (
  input  logic                  clk_i,
  input  logic                  rstn_i,
  input  logic [1:0]            cmd_i,
  input  logic [addr_width-1:0] cmd_addr_i,
  input  logic [31:0]           cmd_data_i,
  output logic [31:0]           cmd_data_o,
  output logic                  cmd_err_o,
  input  logic [8*CH_NUM-1:0]   slv_avail_i,
  output logic [CH_NUM-1:0]     slv_en_o,
  output logic [2*CH_NUM-1:0]   slv_prio_o,
  output logic [3*CH_NUM-1:0]   slv_len_o,
  output logic                  irq_o
);
  localparam logic [4:0]  CH_LIM   = 5'(CH_NUM);
  localparam logic [31:0] LOCK_KEY = 32'h0000_005A;

  logic [5:0]        ctrl_q  [CH_NUM];
  logic [7:0]        thr_q   [CH_NUM];
  logic [7:0]        avail_q [CH_NUM];
  logic [CH_NUM-1:0] below, below_q, below_prev_q, event_set;
  logic [CH_NUM-1:0] irq_stat_q, irq_en_q, w1c_clr;
  logic              lock_q;

  logic        is_wr, is_rd, hi_bad, aligned, ch_ok, mapped, acc_err, wr_ok;
  logic [7:0]  off;
  logic [1:0]  region;
  logic [3:0]  idx;
  logic        sel_ctrl, sel_stat, sel_thr, sel_istat, sel_ien, sel_lock;
  logic [31:0] rd_data;

  always_comb begin
    is_wr   = (cmd_i == 2'b10);
    is_rd   = (cmd_i == 2'b01);
    off     = cmd_addr_i[7:0];
    region  = off[7:6];
    idx     = off[5:2];
    hi_bad  = ((cmd_addr_i >> 8) != '0);
    aligned = !hi_bad && (off[1:0] == 2'b00);
    ch_ok   = ({1'b0, idx} < CH_LIM);

    sel_ctrl  = aligned && (region == 2'd0) && ch_ok;
    sel_stat  = aligned && (region == 2'd1) && ch_ok;
    sel_thr   = aligned && (region == 2'd2) && ch_ok;
    sel_istat = !hi_bad && (off == 8'hF0);
    sel_ien   = !hi_bad && (off == 8'hF4);
    sel_lock  = !hi_bad && (off == 8'hF8);
    mapped    = sel_ctrl | sel_stat | sel_thr | sel_istat | sel_ien | sel_lock;

    acc_err = (is_wr || is_rd) &&
              (!mapped ||
               (is_wr && sel_stat) ||
               (is_wr && lock_q && (sel_ctrl || sel_thr)));
    wr_ok   = is_wr && !acc_err;
    w1c_clr = (wr_ok && sel_istat) ? cmd_data_i[CH_NUM-1:0] : '0;

    rd_data = '0;
    for (int n = 0; n < CH_NUM; n++) begin
      if (idx == 4'(n)) begin
        if (sel_ctrl) rd_data = {26'd0, ctrl_q[n]};
        if (sel_stat) rd_data = {24'd0, avail_q[n]};
        if (sel_thr)  rd_data = {24'd0, thr_q[n]};
      end
    end
    if (sel_istat) rd_data = 32'(irq_stat_q);
    if (sel_ien)   rd_data = 32'(irq_en_q);
    if (sel_lock)  rd_data = {31'd0, lock_q};

    // A threshold of zero disables the channel's event.
    for (int n = 0; n < CH_NUM; n++) begin
      below[n] = (thr_q[n] != 8'd0) && (avail_q[n] < thr_q[n]);
    end
    event_set = below_q & ~below_prev_q;

    for (int n = 0; n < CH_NUM; n++) begin
      slv_en_o[n]         = ctrl_q[n][0];
      slv_prio_o[2*n +: 2] = ctrl_q[n][2:1];
      slv_len_o[3*n +: 3]  = ctrl_q[n][5:3];
    end
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      for (int n = 0; n < CH_NUM; n++) begin
        ctrl_q[n]  <= '0;
        thr_q[n]   <= '0;
        avail_q[n] <= '0;
      end
      below_q      <= '0;
      below_prev_q <= '0;
      irq_stat_q   <= '0;
      irq_en_q     <= '0;
      lock_q       <= 1'b0;
      cmd_data_o   <= '0;
      cmd_err_o    <= 1'b0;
      irq_o        <= 1'b0;
    end else begin
      for (int n = 0; n < CH_NUM; n++) begin
        avail_q[n] <= slv_avail_i[8*n +: 8];
        if (wr_ok && (idx == 4'(n))) begin
          if (sel_ctrl) ctrl_q[n] <= cmd_data_i[5:0];
          if (sel_thr)  thr_q[n]  <= cmd_data_i[7:0];
        end
      end
      below_q      <= below;
      below_prev_q <= below_q;
      // Set dominates a same-cycle W1C of the same bit.
      irq_stat_q   <= (irq_stat_q & ~w1c_clr) | event_set;
      if (wr_ok && sel_ien) irq_en_q <= cmd_data_i[CH_NUM-1:0];
      if (wr_ok && sel_lock && (cmd_data_i == LOCK_KEY)) lock_q <= 1'b1;
      cmd_err_o <= acc_err;
      if (is_rd) cmd_data_o <= acc_err ? 32'd0 : rd_data;
      irq_o <= |(irq_stat_q & irq_en_q);
    end
  end
endmodule

// File: tb/tb_ctrl_regs_mc.sv
module tb_ctrl_regs_mc;
  localparam int CH = 3;
  localparam int AW = 16;
  localparam int unsigned MASK = (1 << CH) - 1;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [1:0]      cmd = 2'b00;
  logic [AW-1:0]   addr = '0;
  logic [31:0]     wdata = '0;
  logic [31:0]     rdata;
  logic            err;
  logic [8*CH-1:0] avail = '0;
  logic [CH-1:0]   en;
  logic [2*CH-1:0] prio;
  logic [3*CH-1:0] len;
  logic            irq;

  ctrl_regs_mc #(.CH_NUM(CH), .addr_width(AW)) dut (
    .clk_i(clk), .rstn_i(rst_n), .cmd_i(cmd), .cmd_addr_i(addr),
    .cmd_data_i(wdata), .cmd_data_o(rdata), .cmd_err_o(err),
    .slv_avail_i(avail), .slv_en_o(en), .slv_prio_o(prio),
    .slv_len_o(len), .irq_o(irq)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct { bit rd; bit err; int unsigned data; } exp_t;
  exp_t sbq[$];

  // Reference model state: register contents plus short histories of the
  // sampled availability and the threshold in force after each edge.
  int unsigned m_ctrl[CH];
  int unsigned m_thr[CH];
  int unsigned m_stat = 0, m_en = 0;
  bit          m_lock = 0;
  int unsigned in_hist[8][CH];
  int unsigned thr_hist[8][CH];
  int          k = 8;
  bit          exp_irq = 0;

  function automatic bit bel(int unsigned a, int unsigned t);
    return (t != 0) && (a < t);
  endfunction

  task automatic model_reset();
    for (int c = 0; c < CH; c++) begin
      m_ctrl[c] = 0;
      m_thr[c]  = 0;
      for (int h = 0; h < 8; h++) begin
        in_hist[h][c]  = 0;
        thr_hist[h][c] = 0;
      end
    end
    m_stat = 0; m_en = 0; m_lock = 0; k = 8; exp_irq = 0;
    sbq.delete();
  endtask

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      model_reset();
    end else begin
      bit          rd, wr, e;
      int unsigned a, d, rv, ev, clr, rg, ch;
      exp_t        x;
      rd = (cmd == 2'b01);
      wr = (cmd == 2'b10);
      a  = int'(addr);
      d  = wdata;
      ev = 0;
      for (int c = 0; c < CH; c++) begin
        if (bel(in_hist[(k-2)%8][c], thr_hist[(k-2)%8][c]) &&
            !bel(in_hist[(k-3)%8][c], thr_hist[(k-3)%8][c]))
          ev |= (1 << c);
      end
      exp_irq = (m_stat & m_en) != 0;
      e = 0; rv = 0; clr = 0; rg = 0; ch = 0;
      if (rd || wr) begin
        if (a > 255 || (a % 4) != 0) e = 1;
        else if (a < 192) begin
          rg = a / 64;
          ch = (a % 64) / 4;
          if (ch >= CH) e = 1;
          else if (wr && rg == 1) e = 1;
          else if (wr && m_lock) e = 1;
        end else if (!(a == 240 || a == 244 || a == 248)) e = 1;
        if (!e) begin
          if (a < 192) begin
            if (rg == 0)      rv = m_ctrl[ch];
            else if (rg == 1) rv = in_hist[(k-1)%8][ch];
            else              rv = m_thr[ch];
          end else if (a == 240) rv = m_stat;
          else if (a == 244)     rv = m_en;
          else                   rv = m_lock;
          if (wr) begin
            if (a < 192 && rg == 0)      m_ctrl[ch] = d & 63;
            else if (a < 192 && rg == 2) m_thr[ch]  = d & 255;
            else if (a == 240)           clr = d & MASK;
            else if (a == 244)           m_en = d & MASK;
            else if (a == 248 && d == 32'h5A) m_lock = 1;
          end
        end
        x.rd = rd; x.err = e; x.data = e ? 0 : rv;
        sbq.push_back(x);
      end
      m_stat = (m_stat & ~clr) | ev;
      for (int c = 0; c < CH; c++) begin
        in_hist[k%8][c]  = int'(avail[8*c +: 8]);
        thr_hist[k%8][c] = m_thr[c];
      end
      k++;
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, expv, $time);
    end
  endtask

  // Monitor: notes whether the bus carried a command at each edge and pops
  // the matching expectation half a cycle later.
  logic [31:0] hold = '0;
  initial begin
    bit   had;
    bit   e_err;
    exp_t x;
    forever begin
      @(posedge clk);
      had = rst_n && (cmd == 2'b01 || cmd == 2'b10);
      @(negedge clk);
      e_err = 0;
      if (!rst_n) hold = '0;
      if (had) begin
        if (sbq.size() == 0) begin
          n_cmp++; n_bad++;
          $display("FAIL sb_empty: command seen, no expectation at %0t", $time);
        end else begin
          x = sbq.pop_front();
          e_err = x.err;
          if (x.rd) hold = x.data;
        end
      end
      chk("cmd_err", {31'd0, err}, {31'd0, e_err});
      chk("cmd_data", rdata, hold);
      chk("irq", {31'd0, irq}, {31'd0, exp_irq});
      for (int c = 0; c < CH; c++) begin
        chk("slv_en",   {31'd0, en[c]},         m_ctrl[c] & 1);
        chk("slv_prio", {30'd0, prio[2*c +: 2]}, (m_ctrl[c] >> 1) & 3);
        chk("slv_len",  {29'd0, len[3*c +: 3]},  (m_ctrl[c] >> 3) & 7);
      end
    end
  end

  task automatic issue(input logic [1:0] c, input int unsigned a, input logic [31:0] d);
    @(posedge clk); #1;
    cmd = c; addr = a[AW-1:0]; wdata = d;
  endtask
  task automatic wr(input int unsigned a, input logic [31:0] d); issue(2'b10, a, d); endtask
  task automatic rd(input int unsigned a); issue(2'b01, a, 32'd0); endtask
  task automatic idle(input int n);
    for (int i = 0; i < n; i++) issue(2'b00, 0, 32'd0);
  endtask
  task automatic set_avail(input int c, input logic [7:0] v);
    avail[8*c +: 8] = v;
  endtask
  task automatic do_reset(input int cycles);
    @(negedge clk); #1;
    rst_n = 1'b0; cmd = 2'b00;
    repeat (cycles) @(negedge clk);
    #1 rst_n = 1'b1;
  endtask
  task automatic read_all();
    for (int c = 0; c < CH; c++) begin
      rd(4*c); rd(8'h40 + 4*c); rd(8'h80 + 4*c);
    end
    rd(8'hF0); rd(8'hF4); rd(8'hF8);
  endtask

  initial begin
    int unsigned alist[19];
    alist = '{32'h00, 32'h04, 32'h08, 32'h0C, 32'h40, 32'h44, 32'h48, 32'h4C,
              32'h80, 32'h84, 32'h88, 32'h8C, 32'hF0, 32'hF4, 32'hF8, 32'hFC,
              32'h41, 32'h102, 32'hF2};
    repeat (3) @(negedge clk);
    #1 rst_n = 1'b1;

    read_all();
    wr(8'h04, 32'h0000_003F); rd(8'h04);
    wr(8'h04, 32'hFFFF_FFFF); rd(8'h04);

    set_avail(2, 8'h20); idle(3);
    wr(8'h88, 32'h10); wr(8'hF4, 32'h4); idle(3);
    set_avail(2, 8'h0F); idle(6);
    rd(8'hF0); wr(8'hF0, 32'h4); idle(3); idle(5); rd(8'hF0);

    rd(8'h0C); rd(8'h41); wr(8'h40, 32'h1); rd(16'h0100); rd(8'hFC); rd(8'h00);

    set_avail(0, 8'h20); idle(3);
    wr(8'h80, 32'h10); wr(8'hF4, 32'h5); wr(8'hF0, 32'h7); idle(3);
    set_avail(0, 8'h0F);
    idle(1);
    wr(8'hF0, 32'h1);
    idle(1); rd(8'hF0); idle(3);

    wr(8'hF8, 32'h12); rd(8'hF8);
    wr(8'hF8, 32'h5A); wr(8'h00, 32'h1); rd(8'h00);
    wr(8'hF4, 32'h1); rd(8'hF4); wr(8'h80, 32'h33); rd(8'h80); rd(8'hF8);

    wr(8'h00, 32'h1);
    do_reset(2);
    read_all();

    for (int i = 0; i < 1500; i++) begin
      int unsigned r, a;
      logic [31:0] d;
      if (i % 300 == 299) do_reset(1 + (i / 300) % 2);
      r = $urandom_range(0, 9);
      a = ($urandom_range(0, 9) == 0) ? ($urandom & 32'h1FF) : alist[$urandom_range(0, 18)];
      d = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 63)) : 32'($urandom);
      if (a == 32'hF8 && $urandom_range(0, 7) == 0) d = 32'h5A;
      if (r <= 3)      issue(2'b00, 0, 32'd0);
      else if (r <= 6) rd(a);
      else             wr(a, d);
      if ($urandom_range(0, 5) == 0)
        set_avail($urandom_range(0, CH-1), 8'($urandom_range(0, 48)));
    end
    idle(6);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
